// File: rtl/expr_pkg.sv
// Shared definitions for the expression transmit link.
// Contents:
//   ASCII constants        CH_ZERO, CH_PLUS, CH_MINUS, CH_MUL, CH_DIV
//   operator codes         OP_ADD, OP_SUB, OP_MUL, OP_DIV (tok_val[1:0])
//   grammar state encoding S_NUM, S_OP, S_SKIP
//   fifo_entry_t           {last, ch[7:0]} as stored in the output byte FIFO
//   digit_char / op_char   token-to-ASCII helpers
package expr_pkg;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Grammar state: expecting a digit, expecting an operator, or discarding
  // the remainder of a rejected expression.
  localparam logic [1:0] S_NUM  = 2'd0;
  localparam logic [1:0] S_OP   = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;

  typedef struct packed {
    logic       last;
    logic [7:0] ch;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic [1:0] code);
    logic [7:0] ch;
    case (code)
      OP_ADD:  ch = CH_PLUS;
      OP_SUB:  ch = CH_MINUS;
      OP_MUL:  ch = CH_MUL;
      default: ch = CH_DIV;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/expr_tx_byte_fifo.sv
// Small synchronous FIFO holding the characters waiting for the sink.
// Ports:
//   clk, clr       clock and synchronous active-high clear
//   push, push_data write one entry (ignored when full)
//   pop            remove the head entry (ignored when empty)
//   head           current head entry, valid whenever !empty
//   empty          no entries held
//   full_nxt       FIFO will be full after this clock edge
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;   // one extra bit so full and empty differ

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  assign full_nxt = (count_d == CW'(DEPTH));
  assign head     = mem_q[rd_ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, so clearing the pointers is enough and keeps the array cheap.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/expr_tx.sv
// Transmit end of the ASCII expression link.
// Accepts digit/operator tokens, checks them against the grammar
// digit (op digit)* and queues the ASCII characters of well-formed tokens
// for a sink that takes one character per handshake.
// Ports:
//   clk, clr                       clock, synchronous active-high clear
//   tok_valid/tok_ready            token handshake
//   tok_op, tok_val, tok_last      token kind, value, end-of-expression flag
//   out, out_valid/out_ready       character handshake (out = 0 when idle)
//   err                            one-cycle pulse: expression rejected
//   done                           one-cycle pulse: final character taken
module expr_tx
  import expr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic       tok_op,
  input  logic [3:0] tok_val,
  input  logic       tok_last,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic       done
);

  logic [1:0]  state_q, state_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        tok_ready_q, tok_ready_d;

  logic        accept;
  logic        reject;
  logic        push;
  fifo_entry_t push_entry;
  logic        pop;
  fifo_entry_t head_entry;
  logic [ENTRY_W-1:0] head_raw;
  logic        fifo_empty;
  logic        fifo_full_nxt;

  assign accept = tok_valid & tok_ready_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    reject     = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      case (state_q)
        S_NUM: begin
          if (!tok_op && tok_val <= 4'd9) begin
            push       = 1'b1;
            push_entry = '{last: tok_last, ch: digit_char(tok_val)};
            state_d    = tok_last ? S_NUM : S_OP;
          end else begin
            reject = 1'b1;
          end
        end
        S_OP: begin
          // A trailing operator is as malformed as an unknown one.
          if (tok_op && tok_val[3:2] == 2'b00 && !tok_last) begin
            push       = 1'b1;
            push_entry = '{last: 1'b0, ch: op_char(tok_val[1:0])};
            state_d    = S_NUM;
          end else begin
            reject = 1'b1;
          end
        end
        S_SKIP: begin
          if (tok_last) state_d = S_NUM;
        end
        default: state_d = S_NUM;
      endcase
      if (reject) state_d = tok_last ? S_NUM : S_SKIP;
    end
  end

  assign head_entry = fifo_entry_t'(head_raw);
  assign pop        = out_ready & ~fifo_empty;

  always_comb begin
    err_d  = reject;
    done_d = pop & head_entry.last;
    // Dropping tokens needs no FIFO space, so skipping never back-pressures.
    // The ready flag follows the post-edge occupancy, so a pop from a full
    // FIFO reopens the token side one cycle later.
    tok_ready_d = (state_d == S_SKIP) | ~fifo_full_nxt;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_NUM;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      tok_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      done_q      <= done_d;
      tok_ready_q <= tok_ready_d;
    end
  end

  byte_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_raw),
    .empty     (fifo_empty),
    .full_nxt  (fifo_full_nxt)
  );

  assign tok_ready = tok_ready_q;
  assign out_valid = ~fifo_empty;
  assign out       = fifo_empty ? 8'h00 : head_entry.ch;
  assign err       = err_q;
  assign done      = done_q;

endmodule
